multiplexer_scan_04: RTL and testbench
======================================

# multiplexer_scan_04

Parametrised, registered N-channel multiplexer with manual and auto-scan modes. It selects one WIDTH-bit lane from a flattened input bus and registers it to OUT. In manual mode SEL chooses the lane. In scan mode the block steps through the enabled channels round-robin, holding each channel for a programmable dwell time. It is the clocked, generalised successor to the fixed 4:1 conditional multiplexer and feeds time-division readout/display paths.

## Interface
- WIDTH, 4, bits per channel
- SEL_W, 2, select width; CHANNELS = 2**SEL_W
- DWELL_W, 8, width of dwell-count input
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- MODE  input  1  0 = manual, 1 = auto-scan
- SEL  input  SEL_W  manual channel select
- EN  input  CHANNELS  per-channel enable mask for scan and VALID
- DWELL  input  DWELL_W  cycles per channel in scan; 0 treated as 1
- HOLD  input  1  freeze all state
- IN  input  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- OUT  output  WIDTH  registered selected lane
- CH  output  SEL_W  channel currently driving OUT
- VALID  output  1  OUT comes from an enabled channel
- WRAP  output  1  one-cycle pulse when scan wraps to a channel ≤ previous CH

## Operation
- Reset (RST=1 at a CLK edge): OUT=0, CH=0, VALID=0, WRAP=0, dwell counter=0, state=MANUAL. RST overrides HOLD and every other input.
- Priority at each edge: RST > HOLD > mode logic.
- HOLD=1: OUT, CH, VALID, state and counter unchanged; WRAP=0.
- States: MANUAL, SCAN, STALL.
- MANUAL (MODE=0):
  - CH<=SEL, OUT<=IN[SEL], VALID<=EN[SEL], WRAP=0, counter=0.
  - MODE=1 moves to SCAN; if EN is all zero, moves to STALL.
- SCAN (MODE=1):
  - OUT<=IN[CH] every cycle, so live data tracks the current channel. VALID=1.
  - Counter increments each cycle. At count = max(DWELL,1)−1, CH advances to the next enabled channel in ascending order, wrapping modulo CHANNELS, and the counter clears.
  - WRAP=1 in the cycle CH takes a value ≤ its previous value. With a single enabled channel, CH is unchanged and WRAP pulses at every dwell expiry.
  - If EN[CH] drops, CH advances to the next enabled channel on the next edge, regardless of the counter, and the counter clears.
  - EN all zero: go to STALL.
  - MODE=0: go to MANUAL.
- Entry MANUAL→SCAN: CH is kept if EN[CH]=1, otherwise advanced to the next enabled channel; counter=0.
- STALL: VALID=0; OUT and CH hold; counter=0; WRAP=0.
  - When any EN bit rises, CH becomes the lowest enabled channel and the state returns to SCAN (MANUAL if MODE=0).
- DWELL changes take effect at the next comparison. If the counter is already ≥ the new limit, advance on the next edge.

## Timing
- Manual latency: 1 cycle. A SEL or IN change at edge n appears on OUT/CH after edge n+1.
- Scan: each enabled channel drives CH for exactly max(DWELL,1) consecutive cycles, absent HOLD or EN changes.
- OUT is 1 cycle behind IN for the current CH.
- The CH and OUT transition happen on the same edge. WRAP is coincident with the CH change.
- HOLD cycles extend the dwell one-for-one.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Manual sweep: IN lanes = {8,4,2,1} (ch3..ch0), EN=4'b1111, SEL stepped 0→1→2→3→0 every 10 cycles. Required: OUT = 1,2,4,8,1, one cycle after each step; CH tracks SEL; VALID=1; WRAP=0.
- Scan full ring: MODE=1, DWELL=3, EN=4'b1111. Required: CH sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; WRAP high only on the 3→0 cycle; OUT matches lane values.
- Sparse mask: EN=4'b1010, DWELL=2. Required: CH alternates 1,1,3,3,1,…; WRAP on each 3→1 transition. Then clear EN[3] mid-dwell. Required: CH stays 1 with WRAP every 2 cycles.
- Stall/recovery: EN→0 during scan. Required: VALID=0 next cycle, OUT/CH frozen. Then set EN=4'b0100. Required: CH=2, VALID=1 on the following edge.
- HOLD and DWELL=0: assert HOLD 5 cycles mid-dwell. Required: no state change; dwell resumes with its remaining count. With DWELL=0, CH advances every cycle.
- Reset mid-scan: RST=1 with HOLD=1 at CH=2. Required: next edge gives OUT=0, CH=0, VALID=0, WRAP=0, state MANUAL.

Source files
------------

// File: rtl/multiplexer_scan_04.sv
// multiplexer_scan_04: registered N-channel lane multiplexer with manual select and round-robin auto-scan
module multiplexer_scan_04 #(
  parameter int WIDTH   = 4,
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          mode_i,
  input  logic [SEL_W-1:0]              sel_i,
  input  logic [(1<<SEL_W)-1:0]         en_i,
  input  logic [DWELL_W-1:0]            dwell_i,
  input  logic                          hold_i,
  input  logic [(1<<SEL_W)*WIDTH-1:0]   in_i,
  output logic [WIDTH-1:0]              out_o,
  output logic [SEL_W-1:0]              ch_o,
  output logic                          valid_o,
  output logic                          wrap_o
);
  localparam int CH_N = 1 << SEL_W;
  localparam logic [1:0] MANUAL = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] STALL  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d, nxt, low;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d, lim_m1;
  logic               valid_q, valid_d, wrap_q, wrap_d, adv;
  logic [WIDTH-1:0]   lane [CH_N];

  for (genvar k = 0; k < CH_N; k++) begin : g_lane
    assign lane[k] = in_i[k*WIDTH +: WIDTH];
  end

  // nxt: next enabled channel after ch_q (itself only if it is the sole one); low: lowest enabled
  always_comb begin
    nxt = ch_q;
    for (int i = CH_N; i >= 1; i--)
      if (en_i[ch_q + SEL_W'(i)]) nxt = ch_q + SEL_W'(i);
    low = '0;
    for (int i = CH_N - 1; i >= 0; i--)
      if (en_i[i]) low = SEL_W'(i);
  end

  // a counter already past a newly lowered limit expires immediately
  assign lim_m1 = (dwell_i == '0) ? '0 : dwell_i - 1'b1;
  assign adv    = !en_i[ch_q] || (cnt_q >= lim_m1);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    out_d   = out_q;
    valid_d = valid_q;
    cnt_d   = '0;
    wrap_d  = 1'b0;
    if (hold_i) begin
      cnt_d = cnt_q;
    end else if (state_q == STALL) begin
      if (|en_i) begin
        state_d = mode_i ? SCAN : MANUAL;
        ch_d    = low;
        out_d   = lane[low];
        valid_d = 1'b1;
      end
    end else if (!mode_i) begin
      state_d = MANUAL;
      ch_d    = sel_i;
      out_d   = lane[sel_i];
      valid_d = en_i[sel_i];
    end else if (en_i == '0) begin
      state_d = STALL;
      valid_d = 1'b0;
    end else if (state_q == MANUAL) begin
      state_d = SCAN;
      ch_d    = en_i[ch_q] ? ch_q : nxt;
      out_d   = lane[ch_d];
      valid_d = 1'b1;
    end else begin
      ch_d    = adv ? nxt : ch_q;
      cnt_d   = adv ? '0 : cnt_q + 1'b1;
      wrap_d  = adv && (nxt <= ch_q);
      out_d   = lane[ch_d];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MANUAL;
      ch_q    <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out_o   = out_q;
  assign ch_o    = ch_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;
endmodule

// File: tb/tb_multiplexer_scan_04.sv
// tb_multiplexer_scan_04: directed self-checking bench for multiplexer_scan_04
module tb_multiplexer_scan_04;
  logic        clk = 1'b0;
  logic        rst, mode, hold;
  logic [1:0]  sel;
  logic [3:0]  en;
  logic [7:0]  dwell;
  logic [15:0] in;
  logic [3:0]  out;
  logic [1:0]  ch;
  logic        valid, wrap;
  int          checks = 0;
  int          errors = 0;

  multiplexer_scan_04 #(.WIDTH(4), .SEL_W(2), .DWELL_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .sel_i(sel), .en_i(en),
    .dwell_i(dwell), .hold_i(hold), .in_i(in),
    .out_o(out), .ch_o(ch), .valid_o(valid), .wrap_o(wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cs(input string tag, input logic [1:0] ech, input logic [3:0] eout,
                    input logic evalid, input logic ewrap);
    chk({tag, ".ch"}, 32'(ch), 32'(ech));
    chk({tag, ".out"}, 32'(out), 32'(eout));
    chk({tag, ".valid"}, 32'(valid), 32'(evalid));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ewrap));
  endtask

  initial begin
    logic [1:0] sw [5];
    logic [3:0] sv [5];
    logic [1:0] sp [7];
    logic [1:0] c;
    sw = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    sv = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    sp = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1, 2'd3};
    rst = 1'b1; hold = 1'b1; mode = 1'b1; sel = 2'd2; en = 4'hF; dwell = 8'd3; in = 16'h8421;
    tick();
    cs("reset", 2'd0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0; hold = 1'b0; mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sel = sw[i];
      if (i > 0) chk("man_latency", 32'(out), 32'(sv[i-1]));
      tick();
      cs("manual", sw[i], sv[i], 1'b1, 1'b0);
      repeat (9) tick();
      chk("man_steady", 32'(out), 32'(sv[i]));
    end
    mode = 1'b1; dwell = 8'd3;
    for (int k = 0; k <= 12; k++) begin
      tick();
      c = 2'((k / 3) % 4);
      cs("ring", c, 4'(1 << c), 1'b1, k == 12);
    end
    en = 4'b1010; dwell = 8'd2;
    for (int k = 0; k < 7; k++) begin
      tick();
      cs("sparse", sp[k], 4'(1 << sp[k]), 1'b1, k == 4);
    end
    en = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      tick();
      cs("single", 2'd1, 4'h2, 1'b1, (k % 2) == 0);
    end
    en = 4'b0000;
    tick();
    cs("stall", 2'd1, 4'h2, 1'b0, 1'b0);
    in = 16'h1234;
    tick();
    cs("stall_frz", 2'd1, 4'h2, 1'b0, 1'b0);
    in = 16'h8421; en = 4'b0100;
    tick();
    cs("recover", 2'd2, 4'h4, 1'b1, 1'b0);
    en = 4'hF; dwell = 8'd4;
    tick();
    cs("pre_hold", 2'd2, 4'h4, 1'b1, 1'b0);
    hold = 1'b1; in = 16'hFFFF;
    repeat (5) begin
      tick();
      cs("hold", 2'd2, 4'h4, 1'b1, 1'b0);
    end
    hold = 1'b0; in = 16'h8421;
    tick();
    cs("resume0", 2'd2, 4'h4, 1'b1, 1'b0);
    tick();
    cs("resume1", 2'd2, 4'h4, 1'b1, 1'b0);
    tick();
    cs("resume_adv", 2'd3, 4'h8, 1'b1, 1'b0);
    dwell = 8'd0;
    tick();
    cs("dwell0_a", 2'd0, 4'h1, 1'b1, 1'b1);
    tick();
    cs("dwell0_b", 2'd1, 4'h2, 1'b1, 1'b0);
    tick();
    cs("dwell0_c", 2'd2, 4'h4, 1'b1, 1'b0);
    rst = 1'b1; hold = 1'b1;
    tick();
    cs("rst_mid", 2'd0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0; hold = 1'b0; mode = 1'b0; sel = 2'd3;
    tick();
    cs("post_rst", 2'd3, 4'h8, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
